sdram_chip_responder: RTL and testbench

- Synthesizable SDRAM device-side responder: the chip end of the SDRAM command bus that our SDRAM controller drives.
- Decodes CS/RAS/CAS/WE commands, tracks the init sequence, bank/row state, mode register, CAS latency and bursts.
- Holds a small on-chip memory array and flags protocol/timing violations.
- Used as loopback target for controller bring-up on FPGA and as the bench's DUT-facing memory.

---
 rtl/sdram_chip_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_sdram_chip_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_chip_responder.sv
// Chip end of the SDRAM command bus: tracks init, mode, banks, refresh and bursts over a small array.
// Read data appears cas_lat cycles after READ with no backpressure; illegal commands are dropped and the first error is latched.
module sdram_chip_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic [1:0]  sdram_ba,
    input  logic [11:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        chip_ready,
    output logic [3:0]  burst_len,
    output logic [1:0]  cas_lat,
    output logic        err_valid,
    output logic [3:0]  err_code,
    output logic [15:0] refresh_cnt
);
    localparam int AW   = 2 + ROW_BITS + COL_BITS;
    localparam int RFCW = $clog2(T_RFC + 1);

    typedef enum logic [2:0] {S_UNINIT, S_PRE, S_REF1, S_REF2, S_READY} init_state_t;
    typedef enum logic [2:0] {
        C_MRS  = 3'b000, C_AREF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
        C_WR   = 3'b100, C_RD   = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
    } cmd_t;

    init_state_t         r_state, w_state_nxt;
    logic [1:0]          r_bl_code, r_cl;
    logic [3:0]          r_open;
    logic [ROW_BITS-1:0] r_row [4];
    logic [2:0]          r_tmr [4];
    logic [RFCW-1:0]     r_rfc;
    logic [15:0]         r_refresh_cnt;
    logic                r_err_valid;
    logic [3:0]          r_err_code;
    logic                r_bst_act, r_bst_wr, r_bst_ap;
    logic [1:0]          r_bst_ba;
    logic [ROW_BITS-1:0] r_bst_row;
    logic [COL_BITS-1:0] r_bst_col;
    logic [2:0]          r_bst_left;
    logic [2:0]          r_pipe_vld;
    logic [15:0]         r_pipe_dat [3];
    logic                r_dq_oe;
    logic [15:0]         r_dq_out;
    logic [15:0]         r_mem [0:(1<<AW)-1];

    cmd_t                w_cmd;
    logic                w_ready, w_any_open, w_mrs_ok, w_err, w_accept;
    logic [3:0]          w_err_code, w_bl;
    logic [COL_BITS-1:0] w_mask;
    logic                w_act_ok, w_rw_ok, w_pre_ok, w_aref_ok, w_mrs_acc, w_bst_ok;
    logic                w_pre_hit, w_ap_close;
    logic                w_beat_vld, w_beat_wr, w_beat_ap;
    logic [1:0]          w_beat_ba;
    logic [ROW_BITS-1:0] w_beat_row;
    logic [COL_BITS-1:0] w_beat_col, w_col_nxt;
    logic [2:0]          w_beat_left;
    logic [AW-1:0]       w_beat_addr;
    logic                w_unused;

    assign w_cmd      = (sdram_cke && !sdram_cs_n) ? cmd_t'({sdram_ras_n, sdram_cas_n, sdram_we_n}) : C_NOP;
    assign w_ready    = (r_state == S_READY);
    assign w_any_open = |r_open;
    assign w_bl       = 4'd1 << r_bl_code;
    assign w_mask     = COL_BITS'(w_bl - 4'd1);
    assign w_mrs_ok   = (sdram_addr[2:0] <= 3'd3) && (sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3);
    assign w_unused   = ^sdram_addr;

    // tRFC lockout outranks every other check; a rejected command has no side effects.
    always_comb begin
        w_err      = 1'b0;
        w_err_code = 4'd0;
        w_accept   = 1'b0;
        if (w_cmd != C_NOP && r_rfc != '0) begin
            w_err      = 1'b1;
            w_err_code = 4'd9;
        end else begin
            case (w_cmd)
                C_ACT: begin
                    if (!w_ready)                         begin w_err = 1'b1; w_err_code = 4'd1; end
                    else if (r_open[sdram_ba])            begin w_err = 1'b1; w_err_code = 4'd4; end
                    else if (r_tmr[sdram_ba] != 3'd0)     begin w_err = 1'b1; w_err_code = 4'd5; end
                    else                                  w_accept = 1'b1;
                end
                C_RD, C_WR: begin
                    if (!w_ready)                         begin w_err = 1'b1; w_err_code = 4'd1; end
                    else if (!r_open[sdram_ba])           begin w_err = 1'b1; w_err_code = 4'd6; end
                    else if (r_tmr[sdram_ba] != 3'd0)     begin w_err = 1'b1; w_err_code = 4'd7; end
                    else                                  w_accept = 1'b1;
                end
                C_AREF: begin
                    if (w_any_open)                       begin w_err = 1'b1; w_err_code = 4'd8; end
                    else                                  w_accept = 1'b1;
                end
                C_MRS: begin
                    if (w_any_open)                       begin w_err = 1'b1; w_err_code = 4'd3; end
                    else if (!w_mrs_ok)                   begin w_err = 1'b1; w_err_code = 4'd2; end
                    else                                  w_accept = 1'b1;
                end
                C_PRE, C_BST: w_accept = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_act_ok  = w_accept && (w_cmd == C_ACT);
    assign w_rw_ok   = w_accept && (w_cmd == C_RD || w_cmd == C_WR);
    assign w_pre_ok  = w_accept && (w_cmd == C_PRE);
    assign w_aref_ok = w_accept && (w_cmd == C_AREF);
    assign w_mrs_acc = w_accept && (w_cmd == C_MRS);
    assign w_bst_ok  = w_accept && (w_cmd == C_BST);
    assign w_pre_hit = w_pre_ok && r_bst_act && (sdram_addr[10] || sdram_ba == r_bst_ba);

    // One beat per cycle: a new READ/WRITE command takes over from any running burst.
    always_comb begin
        w_beat_vld  = 1'b0;
        w_beat_wr   = r_bst_wr;
        w_beat_ap   = r_bst_ap;
        w_beat_ba   = r_bst_ba;
        w_beat_row  = r_bst_row;
        w_beat_col  = r_bst_col;
        w_beat_left = r_bst_left - 3'd1;
        if (w_rw_ok) begin
            w_beat_vld  = 1'b1;
            w_beat_wr   = (w_cmd == C_WR);
            w_beat_ap   = sdram_addr[10];
            w_beat_ba   = sdram_ba;
            w_beat_row  = r_row[sdram_ba];
            w_beat_col  = sdram_addr[COL_BITS-1:0];
            w_beat_left = 3'(w_bl - 4'd1);
        end else if (r_bst_act && !w_pre_hit) begin
            w_beat_vld  = 1'b1;
        end
    end

    assign w_beat_addr = {w_beat_ba, w_beat_row, w_beat_col};
    assign w_col_nxt   = (w_beat_col & ~w_mask) | ((w_beat_col + COL_BITS'(1)) & w_mask);
    assign w_ap_close  = w_beat_vld && w_beat_ap && (w_beat_left == 3'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_UNINIT: if (w_pre_ok && sdram_addr[10]) w_state_nxt = S_PRE;
            S_PRE:    if (w_aref_ok)                  w_state_nxt = S_REF1;
            S_REF1:   if (w_aref_ok)                  w_state_nxt = S_REF2;
            S_REF2:   if (w_mrs_acc)                  w_state_nxt = S_READY;
            default: ;
        endcase
    end

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_state       <= S_UNINIT;
            r_bl_code     <= 2'd0;
            r_cl          <= 2'd2;
            r_open        <= 4'd0;
            r_rfc         <= '0;
            r_refresh_cnt <= 16'd0;
            r_err_valid   <= 1'b0;
            r_err_code    <= 4'd0;
            r_bst_act     <= 1'b0;
            r_bst_wr      <= 1'b0;
            r_bst_ap      <= 1'b0;
            r_bst_ba      <= 2'd0;
            r_bst_row     <= '0;
            r_bst_col     <= '0;
            r_bst_left    <= 3'd0;
            r_pipe_vld    <= 3'd0;
            r_dq_oe       <= 1'b0;
            r_dq_out      <= 16'd0;
            for (int b = 0; b < 4; b++) begin
                r_row[b] <= '0;
                r_tmr[b] <= 3'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_mrs_acc) begin
                r_bl_code <= sdram_addr[1:0];
                r_cl      <= sdram_addr[5:4];
            end
            if (w_aref_ok) begin
                r_refresh_cnt <= r_refresh_cnt + 16'd1;
                r_rfc         <= RFCW'(T_RFC - 1);
            end else if (r_rfc != '0) begin
                r_rfc <= r_rfc - RFCW'(1);
            end
            if (w_err && !r_err_valid) begin
                r_err_valid <= 1'b1;
                r_err_code  <= w_err_code;
            end
            // A bank's single timer counts tRP while closed and tRCD while open.
            for (int b = 0; b < 4; b++) begin
                if (r_tmr[b] != 3'd0)
                    r_tmr[b] <= r_tmr[b] - 3'd1;
                if (w_act_ok && sdram_ba == 2'(b)) begin
                    r_open[b] <= 1'b1;
                    r_row[b]  <= sdram_addr[ROW_BITS-1:0];
                    r_tmr[b]  <= 3'(T_RCD - 1);
                end else if ((w_pre_ok && (sdram_addr[10] || sdram_ba == 2'(b))) ||
                             (w_ap_close && w_beat_ba == 2'(b))) begin
                    r_open[b] <= 1'b0;
                    r_tmr[b]  <= 3'(T_RP - 1);
                end
            end
            if (w_beat_vld) begin
                r_bst_act  <= (w_beat_left != 3'd0) && !w_bst_ok;
                r_bst_wr   <= w_beat_wr;
                r_bst_ap   <= w_beat_ap;
                r_bst_ba   <= w_beat_ba;
                r_bst_row  <= w_beat_row;
                r_bst_col  <= w_col_nxt;
                r_bst_left <= w_beat_left;
            end else if (w_pre_hit) begin
                r_bst_act <= 1'b0;
            end
            r_pipe_vld <= {r_pipe_vld[1:0], w_beat_vld && !w_beat_wr};
            if (r_cl == 2'd3) begin
                r_dq_oe  <= r_pipe_vld[2];
                r_dq_out <= r_pipe_vld[2] ? r_pipe_dat[2] : 16'd0;
            end else begin
                r_dq_oe  <= r_pipe_vld[1];
                r_dq_out <= r_pipe_vld[1] ? r_pipe_dat[1] : 16'd0;
            end
        end
    end

    always_ff @(posedge clk_100m) begin
        if (w_beat_vld && w_beat_wr) begin
            if (!sdram_dqm[0]) r_mem[w_beat_addr][7:0]  <= sdram_dq_in[7:0];
            if (!sdram_dqm[1]) r_mem[w_beat_addr][15:8] <= sdram_dq_in[15:8];
        end
        r_pipe_dat[0] <= r_mem[w_beat_addr];
        r_pipe_dat[1] <= r_pipe_dat[0];
        r_pipe_dat[2] <= r_pipe_dat[1];
    end

    assign sdram_dq_out = r_dq_out;
    assign sdram_dq_oe  = r_dq_oe;
    assign chip_ready   = w_ready;
    assign burst_len    = w_ready ? w_bl : 4'd0;
    assign cas_lat      = w_ready ? r_cl : 2'd0;
    assign err_valid    = r_err_valid;
    assign err_code     = r_err_code;
    assign refresh_cnt  = r_refresh_cnt;
endmodule

// File: tb/tb_sdram_chip_responder.sv
// Directed bench for sdram_chip_responder: read data checked against a scoreboard of expected words and cycles.
module tb_sdram_chip_responder;
    localparam logic [2:0] C_MRS = 3'b000, C_AREF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100, C_RD   = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

    logic        clk_100m = 1'b0;
    logic        rst;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_dqm;
    logic [15:0] sdram_dq_in;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        chip_ready;
    logic [3:0]  burst_len;
    logic [1:0]  cas_lat;
    logic        err_valid;
    logic [3:0]  err_code;
    logic [15:0] refresh_cnt;

    typedef struct {
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk_100m = ~clk_100m;

    sdram_chip_responder dut (
        .clk_100m    (clk_100m),
        .rst         (rst),
        .sdram_cke   (sdram_cke),
        .sdram_cs_n  (sdram_cs_n),
        .sdram_ras_n (sdram_ras_n),
        .sdram_cas_n (sdram_cas_n),
        .sdram_we_n  (sdram_we_n),
        .sdram_ba    (sdram_ba),
        .sdram_addr  (sdram_addr),
        .sdram_dqm   (sdram_dqm),
        .sdram_dq_in (sdram_dq_in),
        .sdram_dq_out(sdram_dq_out),
        .sdram_dq_oe (sdram_dq_oe),
        .chip_ready  (chip_ready),
        .burst_len   (burst_len),
        .cas_lat     (cas_lat),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .refresh_cnt (refresh_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input int c);
        sb.push_back('{dat: d, cyc: c});
    endtask

    // Advance one clock; on the falling edge compare any read data against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk_100m);
        cyc++;
        @(negedge clk_100m);
        if (sdram_dq_oe || (sb.size() != 0 && sb[0].cyc <= cyc)) begin
            chk("dq_oe", 32'(sdram_dq_oe), 32'd1);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (sdram_dq_oe) begin
                    chk("rd_data", 32'(sdram_dq_out), 32'(e.dat));
                    chk("rd_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a);
        sdram_cs_n = 1'b0;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_ba   = b;
        sdram_addr = a;
        step();
        sdram_cs_n = 1'b1;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
    endtask

    task automatic write4(input logic [1:0] b, input logic [11:0] col, input logic [1:0] m,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
        sdram_dqm   = m;
        sdram_dq_in = d0;
        issue(C_WR, b, col);
        sdram_dq_in = d1;
        step();
        sdram_dq_in = d2;
        step();
        sdram_dq_in = d3;
        step();
        sdram_dq_in = 16'd0;
        sdram_dqm   = 2'b00;
    endtask

    task automatic init_seq();
        issue(C_PRE, 2'd0, 12'h400);
        issue(C_AREF, 2'd0, 12'h000);
        idle(6);
        issue(C_AREF, 2'd0, 12'h000);
        idle(6);
        issue(C_MRS, 2'd0, 12'h022);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   32'(chip_ready),   32'd0);
        chk({tag, "_bl"},      32'(burst_len),    32'd0);
        chk({tag, "_cl"},      32'(cas_lat),      32'd0);
        chk({tag, "_errv"},    32'(err_valid),    32'd0);
        chk({tag, "_errc"},    32'(err_code),     32'd0);
        chk({tag, "_refcnt"},  32'(refresh_cnt),  32'd0);
        chk({tag, "_dq_oe"},   32'(sdram_dq_oe),  32'd0);
        chk({tag, "_dq_out"},  32'(sdram_dq_out), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        sdram_cke   = 1'b1;
        sdram_cs_n  = 1'b1;
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
        sdram_ba    = 2'd0;
        sdram_addr  = 12'd0;
        sdram_dqm   = 2'b00;
        sdram_dq_in = 16'd0;
        idle(2);
        chk_all_zero("reset");
        rst = 1'b0;

        init_seq();
        chk("init_ready",  32'(chip_ready),  32'd1);
        chk("init_bl",     32'(burst_len),   32'd4);
        chk("init_cl",     32'(cas_lat),     32'd2);
        chk("init_refcnt", 32'(refresh_cnt), 32'd2);
        chk("init_errv",   32'(err_valid),   32'd0);

        // BL4 write at col 6 lands on cols 6,7,4,5; read back from col 6 in the same order.
        issue(C_ACT, 2'd1, 12'h003);
        idle(1);
        write4(2'd1, 12'h006, 2'b00, 16'hA001, 16'hB002, 16'hC003, 16'hD004);
        idle(2);
        push(16'hA001, cyc + 3);
        push(16'hB002, cyc + 4);
        push(16'hC003, cyc + 5);
        push(16'hD004, cyc + 6);
        issue(C_RD, 2'd1, 12'h006);
        idle(6);

        write4(2'd1, 12'h010, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        write4(2'd1, 12'h010, 2'b10, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
        idle(1);
        for (int i = 0; i < 4; i++) push(16'hFF34, cyc + 3 + i);
        issue(C_RD, 2'd1, 12'h010);
        idle(6);

        // CL3/BL8: reading from col 4 yields cols 4,5,6 before BURST_STOP ends the burst.
        issue(C_PRE, 2'd0, 12'h400);
        idle(1);
        issue(C_MRS, 2'd0, 12'h033);
        chk("mrs_bl8", 32'(burst_len), 32'd8);
        chk("mrs_cl3", 32'(cas_lat),   32'd3);
        issue(C_ACT, 2'd1, 12'h003);
        idle(1);
        push(16'hC003, cyc + 4);
        push(16'hD004, cyc + 5);
        push(16'hA001, cyc + 6);
        issue(C_RD, 2'd1, 12'h004);
        idle(1);
        issue(C_BST, 2'd0, 12'h000);
        idle(8);
        chk("no_err_yet", 32'(err_valid), 32'd0);

        issue(C_ACT, 2'd2, 12'h001);
        issue(C_RD, 2'd2, 12'h000);
        chk("trcd_errv", 32'(err_valid), 32'd1);
        chk("trcd_errc", 32'(err_code),  32'd7);
        idle(4);
        chk("trcd_dq_oe", 32'(sdram_dq_oe), 32'd0);

        rst = 1'b1;
        #1;
        chk_all_zero("rst2");
        idle(1);
        rst = 1'b0;

        issue(C_RD, 2'd0, 12'h000);
        chk("uninit_errv", 32'(err_valid), 32'd1);
        chk("uninit_errc", 32'(err_code),  32'd1);
        idle(4);
        chk("uninit_dq_oe", 32'(sdram_dq_oe), 32'd0);

        init_seq();
        chk("reinit_ready", 32'(chip_ready), 32'd1);
        issue(C_ACT, 2'd0, 12'h005);
        idle(2);
        issue(C_ACT, 2'd0, 12'h005);
        chk("first_err_kept", 32'(err_code), 32'd1);

        // Reset while a read burst is on the bus must drop dq_oe at once.
        write4(2'd0, 12'h000, 2'b00, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
        idle(1);
        push(16'h5555, cyc + 3);
        issue(C_RD, 2'd0, 12'h000);
        idle(2);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_burst");
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
